bounce_generator: RTL

Synthesisable switch-bounce emulator: the transmitting end of the switch-cleanup path. It converts a clean requested level into a raw, bouncing signal with pseudo-random inter-edge gaps, followed by a settle period. It sits on the 5 MHz `clock` domain ahead of the cleanup module, so the cleanup module can be exercised repeatably on the board and in simulation without a real pushbutton.

---
 rtl/bounce_pkg.sv | 19 +
 rtl/lfsr16.sv | 24 ++
 rtl/bounce_generator.sv | 119 +++++++++++
 3 files changed

// File: rtl/bounce_pkg.sv
// Shared constants for the switch-bounce emulator: FSM state encoding,
// LFSR feedback taps, default seed and a small elaboration helper.
package bounce_pkg;

  // Prefixed so the literals cannot collide with the SETTLE parameter of the top.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] state_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      state_reg <= {1'b0, state_reg[15:1]} ^ (state_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign out = state_reg;

endmodule

// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean requested level into a burst of
// 2*BOUNCES+1 toggles with LFSR-randomised gaps, then holds for SETTLE cycles.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int          BOUNCES  = 3,
  parameter int          MIN_GAP  = 250,
  parameter int          GAP_BITS = 10,
  parameter int          SETTLE   = 25000,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       press,
  output logic       raw,
  output logic       busy,
  output logic [7:0] bounce_count
);

  localparam int GAP_MAX = MIN_GAP + (1 << GAP_BITS) - 1;
  localparam int CNT_W   = $clog2(max_int(GAP_MAX, SETTLE) + 1);
  localparam int TOGGLES = 2 * BOUNCES + 1;
  localparam int TOG_W   = $clog2(TOGGLES + 1);
  localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_BITS) - 32'd1);

  state_t             state_reg, state_next;
  logic               raw_reg, raw_next;
  logic               target_reg, target_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [TOG_W-1:0]   tog_reg, tog_next;
  logic [7:0]         count_reg, count_next, count_inc;
  logic [15:0]        lfsr;
  logic [CNT_W-1:0]   gap_value;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (SEED),
    .out   (lfsr)
  );

  assign gap_value = CNT_W'(MIN_GAP) + CNT_W'(lfsr & GAP_MASK);
  assign count_inc = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      raw_reg    <= 1'b0;
      target_reg <= 1'b0;
      cnt_reg    <= '0;
      tog_reg    <= '0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      raw_reg    <= raw_next;
      target_reg <= target_next;
      cnt_reg    <= cnt_next;
      tog_reg    <= tog_next;
      count_reg  <= count_next;
    end
  end

  // The counter holds the remaining cycles to the next toggle (BOUNCE) or to
  // the end of the hold (SETTLE); a value of 1 means "this edge expires".
  always_comb begin
    state_next  = state_reg;
    raw_next    = raw_reg;
    target_next = target_reg;
    cnt_next    = cnt_reg;
    tog_next    = tog_reg;
    count_next  = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (press != raw_reg) begin
          target_next = press;
          raw_next    = ~raw_reg;
          count_next  = 8'd1;
          tog_next    = TOG_W'(1);
          if (BOUNCES == 0) begin
            cnt_next   = CNT_W'(SETTLE);
            state_next = S_SETTLE;
          end else begin
            cnt_next   = gap_value;
            state_next = S_BOUNCE;
          end
        end
      end
      S_BOUNCE: begin
        if (cnt_reg == CNT_W'(1)) begin
          count_next = count_inc;
          tog_next   = tog_reg + TOG_W'(1);
          if (tog_reg == TOG_W'(TOGGLES - 1)) begin
            raw_next   = target_reg;
            cnt_next   = CNT_W'(SETTLE);
            state_next = S_SETTLE;
          end else begin
            raw_next = ~raw_reg;
            cnt_next = gap_value;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign raw          = raw_reg;
  assign busy         = (state_reg != S_IDLE);
  assign bounce_count = count_reg;

endmodule
